xdiv: RTL and testbench
=======================

Name: xdiv

Overview:
- Iterative restoring integer divider functional unit for the data-flow fabric; it is the inverse-operation companion of the fabric multiplier.
- Selects dividend and divisor from the shared flow bus using configuration selectors.
- Computes quotient or remainder, signed or unsigned, one bit per clock.
- Drives a registered result back onto its flow output, with a run/busy/done handshake because latency is multi-cycle.

Parameters:
- DATA_W, 32, operand/result width; also the iteration count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  start request; sampled on rising clk while idle
- flow_in  in  2*`DATABUS_W  shared flow bus; slice k = flow_in[k*DATA_W +: DATA_W]
- configdata  in  `DIV_CONF_BITS  {sela[`N_W], selb[`N_W], fns[`DIV_FNS_W]}, MSB first
- flow_out  out  DATA_W  registered result
- busy  out  1  high from accept through the final (FIX) cycle
- done  out  1  one-cycle pulse; flow_out valid from this cycle

Behaviour:
- Reset values: flow_out=0, done=0, busy=0, state=IDLE, internal regs=0. Reset asserted mid-operation aborts immediately; no done pulse follows.
- Operand selection: op_a (dividend) = slice sela, op_b (divisor) = slice selb. Both are combinational selections via the input mux.
- fns encoding: DIVU_Q=0, DIVU_R=1, DIV_Q=2, DIV_R=3. Bit1 = signed, bit0 = remainder.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On edge E0 with run=1, latch op_a, op_b and fns.
  - Signed mode: latch the magnitudes and record sign_a and sign_b. |MIN| is treated as unsigned 2^(DATA_W-1).
  - Clear the partial remainder; set cnt=0; go to CALC; set busy=1.
- CALC: each edge E1..E_DATA_W does one restoring step, MSB first:
  - rem = {rem, next dividend bit}.
  - If rem >= divisor: subtract and set quotient bit=1; otherwise quotient bit=0.
  - cnt increments each step. After E_DATA_W go to FIX.
- FIX, at edge E_(DATA_W+1):
  - Apply sign correction in signed mode: negate the quotient if sign_a != sign_b; negate the remainder if sign_a=1.
  - flow_out <= selected result; done <= 1; go to IDLE.
  - busy stays high through the FIX cycle and drops at this edge.
- done is high for exactly one cycle after E_(DATA_W+1). Latency from the run edge to result is DATA_W+1 clocks.
- flow_out holds its last value until the next FIX.
- run while busy=1 is ignored.
- run during the done cycle (state already IDLE) is accepted. Back-to-back throughput is one result per DATA_W+2 clocks.
- Operands are latched at accept; later flow_in/configdata changes do not affect the operation in flight.
- Divide by zero:
  - Quotient = all ones.
  - Remainder = original dividend (sign-restored in signed mode).
  - In signed mode the quotient sign fix is suppressed, so the result is -1.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. This falls out of the magnitude algorithm; no special case is needed.

Optional Feature:
- Macro: XDIV_DIVZERO_FLAG_EN.
- Defined:
  - Adds output port dz (1 bit, reset 0).
  - dz is registered at accept as (op_b == 0) and held until the next accept.
  - dz is valid alongside done.
- Undefined: no dz port; the division-by-zero results are unchanged.

Decomposition:
- Shared defines header xdivdefs.vh: DIV_FNS_W=2, the four fns codes, DIV_CONF_BITS = 2*`N_W + `DIV_FNS_W, and FSM state encodings.
- `N_W and `DATABUS_W come from the existing fabric defines.
- Sub-module: the existing xinmux is instantiated twice (dividend, divisor); the datapath/FSM stays in xdiv.

Test Plan (DATA_W=32):
- DIVU_Q, a=100, b=7, run pulse -> done exactly 33 clocks after the run edge, flow_out=14, busy high 33 cycles. Repeat with DIVU_R -> 2.
- DIV_Q a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3). DIV_R -> 0xFFFFFFFF (-1). DIV_Q a=7, b=0xFFFFFFFE -> 0xFFFFFFFD.
- Divide by zero:
  - DIVU_Q 5/0 -> 0xFFFFFFFF; DIVU_R 5/0 -> 5.
  - DIV_Q 0xFFFFFFFB/0 -> 0xFFFFFFFF; DIV_R -> 0xFFFFFFFB.
  - dz=1 when XDIV_DIVZERO_FLAG_EN is defined.
- Overflow: DIV_Q 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIV_R -> 0.
- run re-pulsed 5 cycles into CALC, with flow_in changed -> ignored; result unchanged. A second run in the done cycle -> accepted; second done comes 34 clocks after the first.
- rst asserted at cycle 10 of CALC -> flow_out=0, busy=0, done=0 immediately, with no later done. Next run 100/7 yields 14 normally.

Source files
------------

// File: rtl/xdiv_pkg.sv
// Shared defines and types for the xdiv restoring divider (fns codes, config layout, FSM states).
// The optional divide-by-zero flag port is enabled by defining XDIV_DIVZERO_FLAG_EN.
`ifndef N_W
`define N_W 3
`endif
`ifndef DATABUS_W
`define DATABUS_W 128
`endif
`ifndef DIV_FNS_W
`define DIV_FNS_W 2
`endif
`ifndef DIVU_Q
`define DIVU_Q 2'd0
`endif
`ifndef DIVU_R
`define DIVU_R 2'd1
`endif
`ifndef DIV_Q
`define DIV_Q 2'd2
`endif
`ifndef DIV_R
`define DIV_R 2'd3
`endif
`ifndef DIV_CONF_BITS
`define DIV_CONF_BITS (2*`N_W + `DIV_FNS_W)
`endif

package xdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } xdiv_state_t;

    // fns bit1 selects signed arithmetic, bit0 selects the remainder.
    function automatic logic fns_is_signed(input logic [`DIV_FNS_W-1:0] fns);
        return fns[1];
    endfunction

    function automatic logic fns_is_rem(input logic [`DIV_FNS_W-1:0] fns);
        return fns[0];
    endfunction

endpackage

// File: rtl/xinmux.sv
// Flow-bus input selector: returns slice sel of the shared flow bus.
module xinmux #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3,
    parameter int IN_W   = 256
) (
    input  logic [IN_W-1:0]   flow_in,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] data
);

    assign data = flow_in[sel*DATA_W +: DATA_W];

endmodule

// File: rtl/xdiv.sv
// Iterative restoring divider: one quotient bit per clock, run/busy/done handshake.
// Defining XDIV_DIVZERO_FLAG_EN adds the dz output (divisor was zero at accept).
module xdiv
    import xdiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic [2*`DATABUS_W-1:0]     flow_in,
    input  logic [`DIV_CONF_BITS-1:0]   configdata,
    output logic [DATA_W-1:0]           flow_out,
    output logic                        busy,
`ifdef XDIV_DIVZERO_FLAG_EN
    output logic                        dz,
`endif
    output logic                        done
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [`N_W-1:0]       sela;
    logic [`N_W-1:0]       selb;
    logic [`DIV_FNS_W-1:0] fns_in;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;

    assign sela   = configdata[`DIV_CONF_BITS-1 -: `N_W];
    assign selb   = configdata[`N_W+`DIV_FNS_W-1 -: `N_W];
    assign fns_in = configdata[`DIV_FNS_W-1:0];

    xinmux #(.DATA_W(DATA_W), .SEL_W(`N_W), .IN_W(2*`DATABUS_W)) u_mux_a (
        .flow_in (flow_in),
        .sel     (sela),
        .data    (op_a)
    );

    xinmux #(.DATA_W(DATA_W), .SEL_W(`N_W), .IN_W(2*`DATABUS_W)) u_mux_b (
        .flow_in (flow_in),
        .sel     (selb),
        .data    (op_b)
    );

    xdiv_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              sign_a;
    logic              sign_b;
    logic              rem_sel;
    logic              b_zero;

    logic              neg_a;
    logic              neg_b;
    logic [DATA_W:0]   shifted;
    logic              step_ge;
    logic [DATA_W-1:0] rem_sub;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;
    logic [DATA_W-1:0] result;

    assign neg_a = fns_is_signed(fns_in) & op_a[DATA_W-1];
    assign neg_b = fns_is_signed(fns_in) & op_b[DATA_W-1];

    // quo doubles as the dividend shift register: its MSB feeds the partial remainder.
    assign shifted = {rem, quo[DATA_W-1]};
    assign step_ge = shifted >= {1'b0, dvs};
    assign rem_sub = shifted[DATA_W-1:0] - dvs;

    // A zero divisor leaves quo all ones; skipping the sign fix keeps it at -1.
    assign q_fix  = ((sign_a ^ sign_b) && !b_zero) ? -quo : quo;
    assign r_fix  = sign_a ? -rem : rem;
    assign result = rem_sel ? r_fix : q_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            rem_sel  <= 1'b0;
            b_zero   <= 1'b0;
            flow_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        sign_a  <= neg_a;
                        sign_b  <= neg_b;
                        quo     <= neg_a ? -op_a : op_a;
                        dvs     <= neg_b ? -op_b : op_b;
                        rem     <= '0;
                        cnt     <= '0;
                        rem_sel <= fns_is_rem(fns_in);
                        b_zero  <= (op_b == '0);
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (step_ge) begin
                        rem <= rem_sub;
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W-1))
                        state <= FIX;
                end
                FIX: begin
                    flow_out <= result;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XDIV_DIVZERO_FLAG_EN
    assign dz = b_zero;
`endif

endmodule

// File: tb/tb_xdiv.sv
// Directed-vector bench for xdiv: driver tasks push expectations, a done-triggered monitor checks them.
module tb_xdiv;

    localparam int DW     = 32;
    localparam int FLOW_W = 256;
    localparam int CONF_W = 8;
    localparam int LAT    = 33;

    logic              clk;
    logic              rst;
    logic              run;
    logic [FLOW_W-1:0] flow_in;
    logic [CONF_W-1:0] configdata;
    logic [DW-1:0]     flow_out;
    logic              busy;
    logic              done;
`ifdef XDIV_DIVZERO_FLAG_EN
    logic              dz;
`endif

    xdiv #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .flow_in    (flow_in),
        .configdata (configdata),
        .flow_out   (flow_out),
        .busy       (busy),
`ifdef XDIV_DIVZERO_FLAG_EN
        .dz         (dz),
`endif
        .done       (done)
    );

    // clock / reset / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic          exp_dz_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_ops(input logic [1:0] fns, input logic [DW-1:0] a, input logic [DW-1:0] b);
        flow_in[1*DW +: DW] = a;
        flow_in[2*DW +: DW] = b;
        configdata = {3'd1, 3'd2, fns};
    endtask

    task automatic start_op(input logic [1:0] fns, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] exp);
        set_ops(fns, a, b);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + LAT);
        exp_dz_q.push_back(b == '0);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within 60 cycles (t=%0t)", $time);
        end
    endtask

    task automatic run_op(input logic [1:0] fns, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp);
        start_op(fns, a, b, exp);
        wait_done();
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got 0x%08h expected no result (t=%0t)", flow_out, $time);
            end else begin
                chk("result", flow_out, exp_q.pop_front());
                chk("latency_cycle", cyc, exp_cyc_q.pop_front());
`ifdef XDIV_DIVZERO_FLAG_EN
                chk("dz", {31'd0, dz}, {31'd0, exp_dz_q.pop_front()});
`else
                void'(exp_dz_q.pop_front());
`endif
            end
        end
    end

    initial begin
        int bc;
        int t1;
        int seen;
        rst = 1'b1;
        run = 1'b0;
        for (int k = 0; k < FLOW_W / DW; k++) flow_in[k*DW +: DW] = $urandom;
        configdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_flow_out", flow_out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // unsigned 100/7 with busy window measurement
        start_op(`DIVU_Q, 32'd100, 32'd7, 32'd14);
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
        end
        chk("busy_cycles", bc, 32'd33);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        run_op(`DIVU_R, 32'd100, 32'd7, 32'd2);
        run_op(`DIV_Q, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_op(`DIV_R, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_op(`DIV_Q, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run_op(`DIV_R, 32'd7, 32'hFFFFFFFE, 32'd1);
        run_op(`DIVU_Q, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF);
        run_op(`DIVU_R, 32'hFFFFFFFF, 32'h10, 32'hF);

        // divide by zero
        run_op(`DIVU_Q, 32'd5, 32'd0, 32'hFFFFFFFF);
        run_op(`DIVU_R, 32'd5, 32'd0, 32'd5);
        run_op(`DIV_Q, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
        run_op(`DIV_R, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);

        // signed overflow
        run_op(`DIV_Q, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op(`DIV_R, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        // run while busy is ignored, operands changed after accept
        start_op(`DIVU_Q, 32'd100, 32'd7, 32'd14);
        repeat (5) @(negedge clk);
        set_ops(`DIVU_R, 32'd50, 32'd3);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        wait_done();
        t1 = cyc;
        // accepted in the done cycle
        start_op(`DIVU_R, 32'd100, 32'd7, 32'd2);
        wait_done();
        chk("back_to_back_gap", cyc - t1, 32'd34);
        @(negedge clk);

        // asynchronous reset mid-calculation
        start_op(`DIVU_Q, 32'd100, 32'd7, 32'd14);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_flow_out", flow_out, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_dz_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = done_seen;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", done_seen, seen);
        run_op(`DIVU_Q, 32'd100, 32'd7, 32'd14);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
